disp_probe_core: RTL and testbench

DISP_PROBE_CORE -- requirements
Module: disp_probe_core

---
 rtl/disp_probe_core_if.sv | 20 ++
 rtl/disp_probe_core.sv | 182 ++++++++++++++++++
 tb/tb_disp_probe_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_probe_core_if.sv
// Video slot bus for disp_probe_core: chip select, strobes, word address and data.
// The master drives the request side; the probe (slave) returns combinational read data.
interface disp_probe_core_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, write, read, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, write, read, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/disp_probe_core.sv
// Pass-through video probe that captures a horizontal run of pixels starting at (X0,Y0).
// Optional per-channel pixel sums are built when DISP_PROBE_SUM_EN is defined.
module disp_probe_core #(
  parameter int MAX_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x,
  input  logic [10:0]         y,
  disp_probe_core_if.slave    bus,
  input  logic [11:0]         si_rgb,
  output logic [11:0]         so_rgb
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [7:0] BUF_END   = 8'(16 + MAX_LEN);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [10:0] x0_q, x0_d;
  logic [10:0] y0_q, y0_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  idx_q, idx_d;
  logic [6:0]  count_q, count_d;
  logic        shortFlag_q, shortFlag_d;

  logic [11:0]   buf_q [MAX_LEN];
  logic          bufWe;
  logic [AW-1:0] bufIdx;
  logic          clearSum;
  logic [31:0]   sumWord;

  logic       wrStrobe, wrCtrl, wrX0, wrY0, wrLen, idleOrDone;
  logic [6:0] lenWr;

  assign so_rgb = si_rgb;

  assign wrStrobe   = bus.cs && bus.write;
  assign wrCtrl     = wrStrobe && (bus.addr[4:0] == 5'd0);
  assign wrX0       = wrStrobe && (bus.addr[4:0] == 5'd1);
  assign wrY0       = wrStrobe && (bus.addr[4:0] == 5'd2);
  assign wrLen      = wrStrobe && (bus.addr[4:0] == 5'd3);
  assign idleOrDone = (state_q == IDLE) || (state_q == DONE);
  assign lenWr      = bus.wr_data[6:0];

  // Abort beats arm, arm beats capture; capture only advances on a fresh coordinate
  // because the target column moves on as soon as a pixel is taken.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    len_d       = len_q;
    idx_d       = idx_q;
    count_d     = count_q;
    shortFlag_d = shortFlag_q;
    bufWe       = 1'b0;
    bufIdx      = '0;
    clearSum    = 1'b0;

    if (idleOrDone) begin
      if (wrX0) x0_d = bus.wr_data[10:0];
      if (wrY0) y0_d = bus.wr_data[10:0];
      if (wrLen) begin
        if (lenWr == 7'd0)           len_d = 7'd1;
        else if (lenWr > MAX_LEN_W)  len_d = MAX_LEN_W;
        else                         len_d = lenWr;
      end
    end

    if (wrCtrl && bus.wr_data[1]) begin
      state_d = IDLE;
    end else if (wrCtrl && bus.wr_data[0] && idleOrDone) begin
      state_d     = ARMED;
      idx_d       = '0;
      count_d     = '0;
      shortFlag_d = 1'b0;
      clearSum    = 1'b1;
    end else begin
      case (state_q)
        ARMED: begin
          if ((x == x0_q) && (y == y0_q)) begin
            bufWe   = 1'b1;
            bufIdx  = '0;
            idx_d   = 7'd1;
            count_d = 7'd1;
            state_d = (len_q == 7'd1) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (y != y0_q) begin
            state_d     = DONE;
            shortFlag_d = 1'b1;
            count_d     = idx_q;
          end else if (x == (x0_q + 11'(idx_q))) begin
            bufWe   = 1'b1;
            bufIdx  = idx_q[AW-1:0];
            idx_d   = idx_q + 7'd1;
            count_d = idx_q + 7'd1;
            if ((idx_q + 7'd1) == len_q) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      len_q       <= MAX_LEN_W;
      idx_q       <= '0;
      count_q     <= '0;
      shortFlag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      shortFlag_q <= shortFlag_d;
    end
  end

  // Capture memory has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (bufWe && !reset) buf_q[bufIdx] <= si_rgb;
  end

`ifdef DISP_PROBE_SUM_EN
  logic [9:0] sumR_q, sumG_q, sumB_q;

  always_ff @(posedge clk) begin
    if (reset || clearSum) begin
      sumR_q <= '0;
      sumG_q <= '0;
      sumB_q <= '0;
    end else if (bufWe) begin
      sumR_q <= sumR_q + 10'(si_rgb[11:8]);
      sumG_q <= sumG_q + 10'(si_rgb[7:4]);
      sumB_q <= sumB_q + 10'(si_rgb[3:0]);
    end
  end

  assign sumWord = {2'b00, sumR_q, sumG_q, sumB_q};
`else
  logic unusedSum;
  assign unusedSum = clearSum;
  assign sumWord   = '0;
`endif

  logic [6:0]    rdOff;
  logic [AW-1:0] rdIdx;
  logic          unusedBits;

  assign rdOff      = bus.addr[6:0];
  assign rdIdx      = AW'(rdOff - 7'd16);
  assign unusedBits = ^{bus.read, bus.addr[13:7], bus.wr_data[31:11]};

  // Zero-latency read mux; the buffer window sits just above the register block.
  always_comb begin
    bus.rd_data = '0;
    case (rdOff)
      7'd0: bus.rd_data = {23'b0, shortFlag_q, count_q, (state_q == DONE)};
      7'd1: bus.rd_data = {21'b0, x0_q};
      7'd2: bus.rd_data = {21'b0, y0_q};
      7'd3: bus.rd_data = sumWord;
      default: begin
        if ((rdOff >= 7'd16) && ({1'b0, rdOff} < BUF_END))
          bus.rd_data = {20'b0, buf_q[rdIdx]};
      end
    endcase
  end

endmodule

// File: tb/tb_disp_probe_core.sv
// Self-checking bench for disp_probe_core: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations (SUM expectation follows DISP_PROBE_SUM_EN).
module tb_disp_probe_core;

  logic        clk;
  logic        reset;
  logic [10:0] x, y;
  logic [11:0] si_rgb, so_rgb;
  int          tests;
  int          fails;
  bit          chk;

  disp_probe_core_if bus ();

  disp_probe_core #(.MAX_LEN(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .x      (x),
    .y      (y),
    .bus    (bus.slave),
    .si_rgb (si_rgb),
    .so_rgb (so_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a capture is "the queue of pixels taken so far"; the next target
  // column is simply X0 plus how many pixels are already in the queue.
  int          mX0, mY0, mLen;
  bit          mActive, mDone, mShort;
  logic [11:0] capQ [$];
  logic [11:0] mBuf [16];
  bit          mBufValid [16];

  always @(posedge clk) begin
    bit wasIdle;
    bit wr;
    int a5, d;
    if (reset) begin
      mX0 = 0; mY0 = 0; mLen = 16;
      mActive = 0; mDone = 0; mShort = 0;
      capQ.delete();
    end else begin
      wasIdle = !mActive;
      wr = bus.cs && bus.write;
      a5 = int'(bus.addr[4:0]);
      d  = int'(bus.wr_data[10:0]);
      if (wr && a5 == 0 && bus.wr_data[1]) begin
        mActive = 0; mDone = 0;
      end else if (wr && a5 == 0 && bus.wr_data[0] && wasIdle) begin
        mActive = 1; mDone = 0; mShort = 0;
        capQ.delete();
      end else if (mActive) begin
        if (capQ.size() > 0 && int'(y) != mY0) begin
          mShort = 1; mDone = 1; mActive = 0;
        end else if (int'(y) == mY0 && int'(x) == (mX0 + capQ.size()) % 2048) begin
          mBuf[capQ.size()] = si_rgb;
          mBufValid[capQ.size()] = 1;
          capQ.push_back(si_rgb);
          if (capQ.size() == mLen) begin
            mDone = 1; mActive = 0;
          end
        end
      end
      if (wr && wasIdle) begin
        if (a5 == 1) mX0 = d;
        if (a5 == 2) mY0 = d;
        if (a5 == 3) mLen = (d % 128 == 0) ? 1 : ((d % 128 > 16) ? 16 : d % 128);
      end
    end
  end

  function automatic void modelRead(input int a, output logic [31:0] v, output bit known);
    int sr, sg, sb;
    known = 1;
    v = '0;
    if (a == 0) v = (32'(mShort) << 8) | (32'(capQ.size()) << 1) | 32'(mDone);
    else if (a == 1) v = 32'(mX0);
    else if (a == 2) v = 32'(mY0);
    else if (a == 3) begin
`ifdef DISP_PROBE_SUM_EN
      sr = 0; sg = 0; sb = 0;
      foreach (capQ[i]) begin
        sr += int'(capQ[i][11:8]);
        sg += int'(capQ[i][7:4]);
        sb += int'(capQ[i][3:0]);
      end
      v = (32'(sr % 1024) << 20) | (32'(sg % 1024) << 10) | 32'(sb % 1024);
`else
      sr = 0; sg = 0; sb = 0;
      v = sr + sg + sb;
`endif
    end else if (a >= 16 && a < 32) begin
      known = mBufValid[a - 16];
      v = {20'b0, mBuf[a - 16]};
    end
  endfunction

  // Per-cycle compare of the pass-through stream and whatever address is on the bus.
  always @(negedge clk) begin
    logic [31:0] ev;
    bit kn;
    if (chk) begin
      tests++;
      if (so_rgb !== si_rgb) begin
        fails++;
        $display("[TB] FAIL stream: so_rgb=%h expected %h", so_rgb, si_rgb);
      end
      modelRead(int'(bus.addr[6:0]), ev, kn);
      if (kn) begin
        tests++;
        if (bus.rd_data !== ev) begin
          fails++;
          $display("[TB] FAIL model_read addr=%0d: got %h expected %h at %0t",
                   bus.addr, bus.rd_data, ev, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [13:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    step();
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
  endtask

  task automatic checkOutput(input string name, input logic [13:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    tests++;
    if (bus.rd_data !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, bus.rd_data, exp);
    end
    bus.addr = '0;
  endtask

  task automatic scanLine(input int yy, input int xs, input int xe, input int hold, input bit white);
    for (int xi = xs; xi <= xe; xi++) begin
      x = 11'(xi);
      y = 11'(yy);
      si_rgb = white ? 12'hFFF : {x[3:0], y[3:0], 4'h5};
      repeat (hold) step();
    end
  endtask

  initial begin
    tests = 0; fails = 0; chk = 0;
    reset = 1'b1; x = '0; y = '0; si_rgb = '0;
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.wr_data = '0;
    step();
    chk = 1;
    step();
    reset = 1'b0;
    step();
    checkOutput("reset status", 14'd0, 32'h0);
    checkOutput("reset x0", 14'd1, 32'h0);
    checkOutput("reset sum", 14'd3, 32'h0);

    // Basic capture
    applyStimulus(14'd1, 32'd100);
    applyStimulus(14'd2, 32'd50);
    applyStimulus(14'd3, 32'd4);
    applyStimulus(14'd0, 32'h1);
    for (int yy = 48; yy <= 51; yy++) scanLine(yy, 90, 109, 1, 0);
    checkOutput("basic status", 14'd0, 32'h9);
    checkOutput("basic buf0", 14'd16, 32'h425);
    checkOutput("basic buf1", 14'd17, 32'h525);
    checkOutput("basic buf2", 14'd18, 32'h625);
    checkOutput("basic buf3", 14'd19, 32'h725);
    checkOutput("basic x0", 14'd1, 32'd100);
    checkOutput("basic y0", 14'd2, 32'd50);
    checkOutput("unmapped", 14'd5, 32'h0);

    // Line-end truncation
    applyStimulus(14'd1, 32'd637);
    applyStimulus(14'd2, 32'd10);
    applyStimulus(14'd3, 32'd8);
    applyStimulus(14'd0, 32'h1);
    scanLine(10, 630, 639, 1, 0);
    scanLine(11, 0, 5, 1, 0);
    checkOutput("lineend status", 14'd0, 32'h107);
    checkOutput("lineend buf0", 14'd16, 32'hDA5);
    checkOutput("lineend buf2", 14'd18, 32'hFA5);

    // Slow pixel tick
    applyStimulus(14'd1, 32'd20);
    applyStimulus(14'd2, 32'd5);
    applyStimulus(14'd3, 32'd2);
    applyStimulus(14'd0, 32'h1);
    scanLine(5, 15, 25, 4, 0);
    checkOutput("slow status", 14'd0, 32'h5);
    checkOutput("slow buf0", 14'd16, 32'h455);
    checkOutput("slow buf1", 14'd17, 32'h555);

    // Abort during capture, then re-arm
    applyStimulus(14'd1, 32'd200);
    applyStimulus(14'd2, 32'd7);
    applyStimulus(14'd3, 32'd8);
    applyStimulus(14'd0, 32'h1);
    scanLine(7, 198, 202, 1, 0);
    applyStimulus(14'd0, 32'h2);
    checkOutput("abort status", 14'd0, 32'h6);
    applyStimulus(14'd0, 32'h1);
    scanLine(7, 195, 210, 1, 0);
    checkOutput("rearm status", 14'd0, 32'h11);

    // Reset during capture, then re-arm
    applyStimulus(14'd0, 32'h1);
    scanLine(7, 198, 201, 1, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midreset status", 14'd0, 32'h0);
    checkOutput("midreset x0", 14'd1, 32'h0);
    applyStimulus(14'd1, 32'd200);
    applyStimulus(14'd2, 32'd7);
    applyStimulus(14'd3, 32'd2);
    applyStimulus(14'd0, 32'h1);
    scanLine(7, 198, 203, 1, 0);
    checkOutput("postreset status", 14'd0, 32'h5);

    // LEN clamp, locked config, arm+abort together
    applyStimulus(14'd1, 32'd300);
    applyStimulus(14'd2, 32'd20);
    applyStimulus(14'd3, 32'd0);
    applyStimulus(14'd0, 32'h1);
    scanLine(20, 298, 305, 1, 0);
    checkOutput("len0 status", 14'd0, 32'h3);
    applyStimulus(14'd3, 32'd100);
    applyStimulus(14'd0, 32'h1);
    applyStimulus(14'd1, 32'd5);
    checkOutput("locked x0", 14'd1, 32'd300);
    scanLine(20, 298, 320, 1, 0);
    checkOutput("len100 status", 14'd0, 32'h21);
    applyStimulus(14'd0, 32'h3);
    checkOutput("armabort status", 14'd0, 32'h20);
    scanLine(20, 298, 305, 1, 0);
    checkOutput("armabort idle", 14'd0, 32'h20);

    // SUM
    applyStimulus(14'd1, 32'd400);
    applyStimulus(14'd2, 32'd30);
    applyStimulus(14'd3, 32'd4);
    applyStimulus(14'd0, 32'h1);
    scanLine(30, 398, 405, 1, 1);
    checkOutput("sum status", 14'd0, 32'h9);
`ifdef DISP_PROBE_SUM_EN
    checkOutput("sum value", 14'd3, 32'h03C0F03C);
`else
    checkOutput("sum value", 14'd3, 32'h0);
`endif

    step();
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
